gate_result_checker: RTL and testbench

Downstream checker for the two-input AND/OR/XOR gate block. It samples each applied input pair {a,b} with the gate's x (AND), y (OR), z (XOR) outputs and recomputes the expected values. It counts vectors and mismatches, tracks coverage of the four input combinations, and reports a pass/fail verdict once the session completes. It sits between the gate block's outputs and the bench/status logic, and replaces per-vector manual inspection of monitor output.

---
 rtl/gate_result_checker.sv | 165 ++++++++++++++++
 tb/tb_gate_result_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_result_checker.sv
// gate_result_checker
// Checks the outputs of a two-input AND/OR/XOR gate block against recomputed
// values. It counts vectors and mismatches, tracks which of the four {a,b}
// combinations were seen, and gives a pass/fail verdict once the session ends.
//
// Optional feature macro: GATE_CHECKER_FIRST_FAIL_EN
//   When defined, the first mismatching vector of a session is latched on
//   first_fail ({a,b,x,y,z}) and flagged by first_fail_vld.
//
// Handshake: in_valid has no ready. Every cycle in which the block is in RUN,
// start is low and the terminal condition is false, a valid vector is taken.
// Vectors that arrive at any other time are dropped.
module gate_result_checker #(
  parameter int CNT_W   = 8,
  parameter int MAX_VEC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  output logic [4:0]       first_fail,
  output logic             first_fail_vld,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MAX_VEC_C = CNT_W'(MAX_VEC);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [4:0]       s1_q, s1_d;
  logic             s1_vld_q, s1_vld_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       cov_q, cov_d;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  logic [4:0]       first_fail_q, first_fail_d;
  logic             first_fail_vld_q, first_fail_vld_d;
`endif

  logic term;
  logic mismatch;
  logic s1_a, s1_b, s1_x, s1_y, s1_z;

  // Unpack the captured vector and recompute the gate outputs
  always_comb begin
    {s1_a, s1_b, s1_x, s1_y, s1_z} = s1_q;
    mismatch = (s1_x != (s1_a & s1_b)) |
               (s1_y != (s1_a | s1_b)) |
               (s1_z != (s1_a ^ s1_b));
    // A vector still in the capture stage must be compared before DONE
    term = ((cov_q == 4'hF) || (vec_cnt_q == MAX_VEC_C)) && !s1_vld_q;
  end

  // Next-state, capture and compare logic
  always_comb begin
    state_d   = state_q;
    s1_d      = s1_q;
    s1_vld_d  = 1'b0;
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    cov_d     = cov_q;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    first_fail_d     = first_fail_q;
    first_fail_vld_d = first_fail_vld_q;
`endif

    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (start) state_d = S_RUN;
               else if (term) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      // start wins over everything: results and the pipeline are discarded
      vec_cnt_d = '0;
      err_cnt_d = '0;
      cov_d     = '0;
      s1_vld_d  = 1'b0;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
      first_fail_d     = '0;
      first_fail_vld_d = 1'b0;
`endif
    end else if (state_q == S_RUN) begin
      if (s1_vld_q) begin
        if (vec_cnt_q != CNT_MAX) vec_cnt_d = vec_cnt_q + 1'b1;
        if (mismatch && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
        cov_d[{s1_a, s1_b}] = 1'b1;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
        if (mismatch && !first_fail_vld_q) begin
          first_fail_d     = s1_q;
          first_fail_vld_d = 1'b1;
        end
`endif
      end
      if (in_valid && !term) begin
        s1_d     = {a, b, x, y, z};
        s1_vld_d = 1'b1;
      end
    end
  end

  // State, pipeline and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      s1_q      <= '0;
      s1_vld_q  <= 1'b0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      cov_q     <= '0;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s1_vld_q  <= s1_vld_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      cov_q     <= cov_d;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
      first_fail_q     <= first_fail_d;
      first_fail_vld_q <= first_fail_vld_d;
`endif
    end
  end

  // Status outputs; pass is only meaningful while done
  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    pass      = done && (err_cnt_q == '0) && (cov_q == 4'hF);
    vec_cnt   = vec_cnt_q;
    err_cnt   = err_cnt_q;
    cov       = cov_q;
    dbg_state = state_q;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    first_fail     = first_fail_q;
    first_fail_vld = first_fail_vld_q;
`endif
  end

endmodule

// File: tb/tb_gate_result_checker.sv
// tb_gate_result_checker
// Directed sessions plus one randomized session. Each accepted vector pushes
// the expected {vec_cnt, err_cnt, cov} into exp_q along with the cycle at
// which the DUT should show it; a negedge monitor pops and compares.
module tb_gate_result_checker;

  localparam int CNT_W   = 8;
  localparam int MAX_VEC = 16;
  localparam int W       = 2 * CNT_W + 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic             a, b, x, y, z;
  logic             busy, done, pass;
  logic [CNT_W-1:0] vec_cnt, err_cnt;
  logic [3:0]       cov;
  logic [1:0]       dbg_state;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  logic [4:0]       first_fail;
  logic             first_fail_vld;
`endif

  gate_result_checker #(.CNT_W(CNT_W), .MAX_VEC(MAX_VEC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .x        (x),
    .y        (y),
    .z        (z),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .vec_cnt  (vec_cnt),
    .err_cnt  (err_cnt),
    .cov      (cov),
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    .first_fail     (first_fail),
    .first_fail_vld (first_fail_vld),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0]     exp_q[$];
  int               due_q[$];
  int               n_chk  = 0;
  int               n_pass = 0;
  logic [CNT_W-1:0] m_vec, m_err;
  logic [3:0]       m_cov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Compare the counters when an accepted vector's result is due
  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      logic [W-1:0] e;
      int           d;
      e = exp_q.pop_front();
      d = due_q.pop_front();
      check("sb_counts", {12'd0, vec_cnt, err_cnt, cov}, {12'd0, e});
      if (d != cyc) check("sb_due_cycle", d, cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    due_q.delete();
    m_vec = '0;
    m_err = '0;
    m_cov = '0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Drive one vector for one cycle; acc says whether the checker should take it
  task automatic vec(input logic va, vb, vx, vy, vz, input logic acc);
    in_valid = 1'b1;
    {a, b, x, y, z} = {va, vb, vx, vy, vz};
    if (acc) begin
      if (m_vec != '1) m_vec = m_vec + 1'b1;
      if (((vx != (va & vb)) || (vy != (va | vb)) || (vz != (va ^ vb))) && (m_err != '1))
        m_err = m_err + 1'b1;
      m_cov[{va, vb}] = 1'b1;
      exp_q.push_back({m_vec, m_err, m_cov});
      due_q.push_back(cyc + 2);
    end
    tick();
  endtask

  task automatic good(input logic va, vb);
    vec(va, vb, va & vb, va | vb, va ^ vb, 1'b1);
  endtask

  task automatic do_start(input logic with_vec);
    start    = 1'b1;
    in_valid = with_vec;
    {a, b, x, y, z} = 5'b10011;
    model_clear();
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] ab;
    logic [2:0] o;
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    {a, b, x, y, z} = '0;
    model_clear();
    repeat (2) tick();
    check("reset_outputs", {busy, done, pass, vec_cnt, err_cnt, cov, dbg_state}, '0);
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    check("reset_first_fail", {first_fail, first_fail_vld}, '0);
`endif
    rst_n = 1'b1;
    tick();

    // in_valid without start is ignored in IDLE
    vec(0, 1, 0, 1, 1, 1'b0);
    vec(1, 1, 1, 1, 0, 1'b0);
    idle(2);
    check("idle_vec_cnt", vec_cnt, 0);
    check("idle_busy", {busy, done}, 2'b00);

    // All four combinations correct: done two cycles after the last vector
    do_start(1'b0);
    check("t1_busy", {busy, done}, 2'b10);
    good(0, 0); good(0, 1); good(1, 0); good(1, 1);
    idle(1);
    check("t1_done_not_yet", done, 0);
    idle(1);
    check("t1_done", {busy, done, pass}, 3'b011);
    check("t1_counts", {vec_cnt, err_cnt, cov}, {8'd4, 8'd0, 4'hF});

    // Restart from DONE with one bad z on {a,b}=01
    do_start(1'b0);
    check("t2_cleared", {busy, done, vec_cnt, err_cnt, cov}, {2'b10, 20'd0});
    good(0, 0);
    vec(0, 1, 0, 1, 0, 1'b1);
    good(1, 0); good(1, 1);
    idle(2);
    check("t2_done", {busy, done, pass}, 3'b010);
    check("t2_err", err_cnt, 1);
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    check("t2_first_fail", {first_fail, first_fail_vld}, {5'b01010, 1'b1});
`endif

    // MAX_VEC forces the end with incomplete coverage
    do_start(1'b0);
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    check("t3_ff_cleared", {first_fail, first_fail_vld}, '0);
`endif
    repeat (MAX_VEC) good(0, 0);
    idle(1);
    check("t3_not_done", done, 0);
    idle(1);
    check("t3_done", {busy, done, pass, cov}, {3'b010, 4'b0001});
    vec(0, 0, 0, 0, 0, 1'b0);
    idle(2);
    check("t3_17th_dropped", vec_cnt, MAX_VEC);

    // Restart mid-session: the in-flight and concurrent vectors are dropped
    do_start(1'b0);
    good(0, 0); good(0, 1);
    do_start(1'b1);
    check("t4_restart_clear", {busy, vec_cnt, err_cnt, cov}, {1'b1, 20'd0});
    good(1, 1);
    idle(2);
    check("t4_still_run", {busy, done}, 2'b10);
    check("t4_counts", {vec_cnt, err_cnt, cov}, {8'd1, 8'd0, 4'b1000});

    // Random session: combos 00/01/10 only, so coverage cannot complete early
    do_start(1'b0);
    repeat (12) begin
      ab = 2'($urandom_range(2, 0));
      o  = {ab[1] & ab[0], ab[1] | ab[0], ab[1] ^ ab[0]};
      if ($urandom_range(3, 0) == 0) o[$urandom_range(2, 0)] ^= 1'b1;
      vec(ab[1], ab[0], o[2], o[1], o[0], 1'b1);
      if ($urandom_range(1, 0) == 1) idle(1);
    end
    idle(2);
    check("t5_not_done", {busy, done}, 2'b10);
    good(1, 1);
    idle(2);
    check("t5_done", {busy, done}, 2'b01);
    check("t5_pass", pass, (m_err == 0) ? 1 : 0);

    // Asynchronous reset mid-session
    do_start(1'b0);
    good(0, 0);
    idle(1);
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", {busy, done, pass, vec_cnt, err_cnt, cov, dbg_state}, '0);
    model_clear();
    #1;
    rst_n = 1'b1;
    vec(1, 1, 1, 1, 0, 1'b0);
    idle(2);
    check("t6_after_reset", {busy, vec_cnt}, '0);

    idle(2);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
